// File: rtl/averager_readout.sv
// averager_readout: streams the averaged record out of BRAM port B as one AXI4-Stream packet,
// with a 2-entry skid FIFO absorbing read latency and back-pressure, and an arithmetic right shift.
module averager_readout #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [15:0]                 nsamples,
    input  logic [4:0]                  shift,
    output logic [31:0]                 bram_addr,
    output logic                        bram_en,
    input  logic [AXIS_TDATA_WIDTH-1:0] bram_rdata,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                      state_q, state_d;
    logic                        start_q, start_d;
    logic [15:0]                 n_q, n_d;
    logic [4:0]                  shift_q, shift_d;
    logic [15:0]                 rd_idx_q, rd_idx_d;
    logic [15:0]                 beat_q, beat_d;
    logic                        inflight_q, inflight_d;
    logic [1:0]                  fifo_count_q, fifo_count_d;
    logic [AXIS_TDATA_WIDTH-1:0] fifo_q [2];
    logic [AXIS_TDATA_WIDTH-1:0] fifo_d [2];
    logic [31:0]                 addr_q, addr_d;
    logic                        start_edge, pop, issue, wr_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            n_q          <= '0;
            shift_q      <= '0;
            rd_idx_q     <= '0;
            beat_q       <= '0;
            inflight_q   <= 1'b0;
            fifo_count_q <= '0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            n_q          <= n_d;
            shift_q      <= shift_d;
            rd_idx_q     <= rd_idx_d;
            beat_q       <= beat_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            addr_q       <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_edge ? ((nsamples != 16'd0) ? READ : DONE) : IDLE;
            READ:    state_d = (rd_idx_d == n_q) ? DRAIN : READ;
            DRAIN:   state_d = (pop && beat_q == n_q - 16'd1) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy counts words held plus the one in flight, so a read never outruns FIFO space.
    always_comb begin
        start_d      = start;
        start_edge   = start & ~start_q;
        pop          = m_axis_tvalid & m_axis_tready;
        issue        = (state_q == READ) && (rd_idx_q != n_q) &&
                       ((3'(fifo_count_q) + 3'(inflight_q)) < (3'(FIFO_DEPTH) + 3'(pop)));
        idle_latch: begin end
        n_d          = n_q;
        shift_d      = shift_q;
        rd_idx_d     = rd_idx_q + 16'(issue);
        beat_d       = beat_q + 16'(pop);
        if (state_q == IDLE && start_edge && nsamples != 16'd0) begin
            n_d      = nsamples;
            shift_d  = shift;
            rd_idx_d = '0;
            beat_d   = '0;
        end
        inflight_d   = issue;
        addr_d       = issue ? {14'd0, rd_idx_q, 2'b00} : addr_q;
        fifo_count_d = fifo_count_q + 2'(inflight_q) - 2'(pop);
        wr_idx       = 1'(fifo_count_q - 2'(pop));
        fifo_d[0]    = pop ? fifo_q[1] : fifo_q[0];
        fifo_d[1]    = fifo_q[1];
        if (inflight_q) fifo_d[wr_idx] = bram_rdata;
    end

    always_comb begin
        bram_en       = issue;
        bram_addr     = issue ? {14'd0, rd_idx_q, 2'b00} : addr_q;
        m_axis_tvalid = fifo_count_q != 2'd0;
        m_axis_tdata  = $signed(fifo_q[0]) >>> shift_q;
        m_axis_tlast  = m_axis_tvalid && (beat_q == n_q - 16'd1);
        busy          = (state_q == READ) || (state_q == DRAIN);
        done          = state_q == DONE;
    end
endmodule

// File: tb/tb_averager_readout.sv
// tb_averager_readout: scoreboard bench for averager_readout with a one-cycle-latency BRAM model.
module tb_averager_readout;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] nsamples = '0;
    logic [4:0]  shift = '0;
    logic [31:0] bram_addr, bram_rdata, tdata;
    logic        bram_en, tvalid, tready = 1'b1, tlast, busy, done;

    averager_readout dut (
        .clk(clk), .reset(reset), .start(start), .nsamples(nsamples), .shift(shift),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_rdata(bram_rdata),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr[7:2]];

    typedef struct { logic [31:0] d; logic l; } beat_t;
    beat_t sb[$];
    int n_cmp = 0, n_bad = 0, beats = 0, dones = 0, ens = 0, busys = 0, outstanding = 0;
    int cyc = 0, rmode = 0;
    logic prev_stall = 1'b0, prev_l;
    logic [31:0] prev_d;

    always @(posedge clk) begin
        #1;
        cyc++;
        tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic pop;
            beat_t e;
            pop = tvalid & tready;
            if (bram_en) begin
                n_cmp++;
                if (outstanding - int'(pop) >= 2) begin
                    n_bad++;
                    $display("FAIL occupancy: read issued with %0d words held/in flight, limit 1", outstanding - int'(pop));
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b", tvalid, tdata, tlast, prev_d, prev_l);
                end
            end
            if (pop) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat: unexpected beat d=%h l=%b, none expected", tdata, tlast);
                end else begin
                    e = sb.pop_front();
                    if (tdata !== e.d || tlast !== e.l) begin
                        n_bad++;
                        $display("FAIL beat: got d=%h l=%b, need d=%h l=%b", tdata, tlast, e.d, e.l);
                    end
                end
                beats++;
            end
            outstanding += int'(bram_en) - int'(pop);
            if (bram_en) ens++;
            if (done) dones++;
            if (busy) busys++;
            prev_stall = tvalid & ~tready;
            prev_d = tdata;
            prev_l = tlast;
        end
    end

    task automatic expect_packet(input int n, input int sh);
        for (int i = 0; i < n; i++) begin
            beat_t e;
            e.d = $signed(mem[i]) >>> sh;
            e.l = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(input int n, input int sh);
        nsamples = 16'(n);
        shift = 5'(sh);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) break;
        end
        n_cmp++;
        if (k == budget) begin
            n_bad++;
            $display("FAIL %s_timeout: no done within %0d cycles, need done", name, budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bram_en, bram_addr, tvalid, tdata, tlast, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: en=%b addr=%h v=%b d=%h l=%b busy=%b done=%b, need all 0",
                     bram_en, bram_addr, tvalid, tdata, tlast, busy, done);
        end
        @(posedge clk); #1 reset = 1'b0;
        outstanding = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bram_en, tvalid, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL post_reset_idle: en=%b v=%b busy=%b done=%b, need all 0", bram_en, tvalid, busy, done);
        end
    endtask

    task automatic test_basic;
        logic tv [1:12];
        logic dn [1:12];
        int ones;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 100);
        rmode = 0;
        expect_packet(8, 0);
        pulse_start(8, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (busy !== 1'b1 || bram_en !== 1'b1 || bram_addr !== 32'h0) begin
                    n_bad++;
                    $display("FAIL first_read: busy=%b en=%b addr=%h, need 1 1 00000000", busy, bram_en, bram_addr);
                end
            end
            tv[k] = tvalid;
            dn[k] = done;
        end
        ones = 0;
        for (int k = 3; k <= 10; k++) ones += int'(tv[k]);
        n_cmp++;
        if (tv[2] !== 1'b0 || tv[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL latency: tvalid at +2=%b +3=%b, need 0 1", tv[2], tv[3]);
        end
        n_cmp++;
        if (ones != 8 || tv[11] !== 1'b0) begin
            n_bad++;
            $display("FAIL throughput: %0d valid cycles in +3..+10, valid at +11=%b, need 8 and 0", ones, tv[11]);
        end
        n_cmp++;
        if (dn[10] !== 1'b0 || dn[11] !== 1'b1 || dn[12] !== 1'b0) begin
            n_bad++;
            $display("FAIL done_timing: done +10/+11/+12 = %b%b%b, need 010", dn[10], dn[11], dn[12]);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL basic_count: %0d beats missing, need 0", sb.size());
        end
    endtask

    task automatic test_shift;
        mem[0] = 32'hFFFF_FF00;
        mem[1] = 32'd1000;
        expect_packet(2, 4);
        pulse_start(2, 4);
        wait_done("shift", 20);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL shift_count: %0d beats missing, need 0", sb.size());
        end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 64; i++) mem[i] = {5'(i), 27'(i * 77 + 5)};
        for (int m = 1; m <= 2; m++) begin
            int b0;
            b0 = beats;
            rmode = m;
            expect_packet(16, 3);
            pulse_start(16, 3);
            wait_done("backpressure", 400);
            n_cmp++;
            if (beats - b0 != 16 || sb.size() != 0) begin
                n_bad++;
                $display("FAIL bp_count: mode %0d got %0d beats, %0d left, need 16 and 0", m, beats - b0, sb.size());
            end
        end
        rmode = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_start_during_busy;
        int b0, d0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 100);
        b0 = beats; d0 = dones;
        expect_packet(4, 0);
        nsamples = 16'd4;
        shift = 5'd0;
        @(posedge clk); #1 start = 1'b1;
        wait_done("held", 30);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (beats - b0 != 4 || dones - d0 != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_held: %0d beats %0d dones busy=%b, need 4 1 0", beats - b0, dones - d0, busy);
        end
        #1 start = 1'b0;
        b0 = beats; d0 = dones;
        expect_packet(4, 0);
        pulse_start(4, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("rearm", 30);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (beats - b0 != 4 || dones - d0 != 1 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL start_busy: %0d beats %0d dones %0d left, need 4 1 0", beats - b0, dones - d0, sb.size());
        end
    endtask

    task automatic test_zero;
        int b0, d0, e0, u0;
        b0 = beats; d0 = dones; e0 = ens; u0 = busys;
        pulse_start(0, 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done: done=%b busy=%b, need 1 0", done, busy);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (beats != b0 || ens != e0 || busys != u0 || dones - d0 != 1) begin
            n_bad++;
            $display("FAIL zero_quiet: beats+%0d en+%0d busy+%0d done+%0d, need 0 0 0 1",
                     beats - b0, ens - e0, busys - u0, dones - d0);
        end
    endtask

    task automatic test_reset_mid;
        int k, d0, b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 100);
        d0 = dones;
        expect_packet(10, 0);
        pulse_start(10, 0);
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tvalid && tdata == 32'd500) break;
        end
        n_cmp++;
        if (k == 30) begin
            n_bad++;
            $display("FAIL reset_mid_timeout: beat 5 never seen, need it within 30 cycles");
        end
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        outstanding = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bram_en, bram_addr, tvalid, tdata, tlast, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_values: en=%b addr=%h v=%b d=%h l=%b busy=%b done=%b, need all 0",
                     bram_en, bram_addr, tvalid, tdata, tlast, busy, done);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (dones != d0 || tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_abort: done+%0d valid=%b, need 0 0", dones - d0, tvalid);
        end
        b0 = beats;
        expect_packet(10, 0);
        pulse_start(10, 0);
        wait_done("reset_restart", 40);
        n_cmp++;
        if (beats - b0 != 10 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL reset_restart: %0d beats %0d left, need 10 0", beats - b0, sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_shift;
        test_backpressure;
        test_start_during_busy;
        test_zero;
        test_reset_mid;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/averager_readout.md
# averager_readout

Streams the averaged record out of the averager's accumulation BRAM as an AXI4-Stream packet once averaging has finished. Sits on the BRAM port B side opposite the averager's write port. Issues sequential word reads, absorbs the one-cycle BRAM read latency and downstream back-pressure in a small FIFO, and applies an optional arithmetic right shift so software can normalise by a power-of-two average count. The output feeds the DMA / AXI-Stream-to-memory path.

## Interface

Parameters:
- AXIS_TDATA_WIDTH, 32, stream and BRAM data width; the block supports only 32.
- FIFO_DEPTH, 2, skid FIFO entries; the block supports only 2.

Ports (clock and reset first). Reset is synchronous and active-high on clk, as already decided.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level input; its rising edge requests one readout. Typically tied to the averager's finished flag.
- nsamples  in  16  number of words to read; latched on the accepted start edge.
- shift  in  5  arithmetic right-shift amount, 0..31; latched on the accepted start edge.
- bram_addr  out  32  byte address, 4*index.
- bram_en  out  1  read enable; the BRAM returns data one cycle later.
- bram_rdata  in  32  BRAM read data, signed two's complement.
- m_axis_tdata  out  32  shifted sample.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  high on the final beat of the packet.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse when a packet completes.

## Operation

- Edge detect: a registered copy of start, cleared by reset. An edge exists when start=1 and the previous value was 0.
- States:
  - IDLE:
    - On a start edge with nsamples>0: latch nsamples and shift, clear the read index and the beat count, go to READ.
    - On a start edge with nsamples=0: go to DONE; no BRAM reads and no beats.
  - READ:
    - Issue a read (bram_en=1, bram_addr=4*rd_idx, then rd_idx+1) when fifo_count + inflight - pop < 2, where pop = m_axis_tvalid & m_axis_tready.
    - When rd_idx reaches the latched nsamples, go to DRAIN.
  - DRAIN: stop issuing reads. After the handshake of beat nsamples-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Start edges outside IDLE are ignored and are not queued.
- Data path:
  - The registered inflight flag marks the cycle in which bram_rdata is valid; in that cycle the word is pushed into the FIFO.
  - m_axis_tdata = $signed(head) >>> shift_latched. Sign bits fill from the left, and shift=0 passes the value through unchanged.
- Stream rules:
  - tvalid, once high, stays high with tdata and tlast stable until the handshake.
  - tlast = (beat count == nsamples-1) for the head beat.
  - The beat count increments on each handshake.
- busy is high in READ and DRAIN, and low in IDLE and DONE.
- The FIFO never overflows; the issue rule guarantees it.
- bram_addr holds its last value when bram_en=0.
- The block never writes the BRAM.
- Reset mid-operation, in any state: go to IDLE, flush the FIFO, clear inflight. No tlast or done is produced for the aborted packet.

## Timing

- Reset values: bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0, done=0.
- Start edge sampled at rising edge T:
  - Cycle T+1: busy=1, bram_en=1, bram_addr=0.
  - Cycle T+2: bram_rdata valid.
  - Cycle T+3: m_axis_tvalid=1 with word 0. Latency is 3 cycles from edge to first valid.
- Throughput: with m_axis_tready held high, one beat per cycle with no bubbles, so N words take N consecutive beat cycles.
- Back-pressure: when tready drops, at most the 2 words already held or in flight are kept. Reads resume in the cycle a pop frees space, and no word is lost or duplicated.
- The last handshake in cycle L gives done=1 and busy=0 in cycle L+1, and IDLE in cycle L+2. A start edge is accepted from cycle L+2 onward.
- nsamples=0: start edge at T gives done=1 in cycle T+1; busy stays 0.
- Address range: the index wraps only at 65535. bram_addr = 4*rd_idx is zero-extended to 32 bits, with a maximum of 0x3FFFC.

## Test plan

- BRAM preloaded with word i = i*100, nsamples=8, shift=0, tready=1 -> 8 beats 0,100,…,700 on consecutive cycles; first tvalid 3 cycles after the start edge; tlast only on 700; done one cycle after that beat.
- BRAM word 0 = 0xFFFFFF00 (-256), word 1 = 1000, shift=4, nsamples=2 -> beats 0xFFFFFFF0 (-16) then 62; tlast on the second beat.
- nsamples=16, tready toggling in a 1-high/3-low pattern, plus a random pattern -> exactly 16 beats in address order, no duplicates; tdata and tlast stable while stalled; bram_en never issued with 2 words held or in flight.
- Start edge during busy, and start held high across the whole packet -> exactly one packet. A new edge after done starts a second identical packet.
- nsamples=0 -> no tvalid, no bram_en, done pulse 1 cycle after the edge, busy never high.
- Reset asserted 1 cycle in the middle of beat 5 of 10 -> all outputs at reset values the next cycle, FIFO empty, no done. A following start edge produces a complete 10-beat packet starting at word 0.
